// File: rtl/serial_adder_nand_pkg.sv
// Shared types and constants for the bit-serial NAND adder datapath.
// Latency: none (declarations only).
// Backpressure: not applicable.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int WIDTH_MAX = 32;

    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/serial_adder_nand_full_adder.sv
// NAND-only half adder and the full-adder cell built from two of them.
// Latency: purely combinational.
// Backpressure: not applicable.
module Half_adder_nand (
    input  logic A,
    input  logic B,
    output logic Sum,
    output logic Carry
);

    logic n1;
    logic n2;
    logic n3;

    assign n1    = ~(A & B);
    assign n2    = ~(A & n1);
    assign n3    = ~(B & n1);
    assign Sum   = ~(n2 & n3);
    assign Carry = ~(n1 & n1);

endmodule

module full_adder_nand (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Sum,
    output logic Cout
);

    logic p;
    logic g1;
    logic g2;
    logic g1_n;
    logic g2_n;

    Half_adder_nand u_ha1 (
        .A     (A),
        .B     (B),
        .Sum   (p),
        .Carry (g1)
    );

    Half_adder_nand u_ha2 (
        .A     (p),
        .B     (Cin),
        .Sum   (Sum),
        .Carry (g2)
    );

    // OR of the two generates by De Morgan: inverters are self-tied NANDs.
    assign g1_n = ~(g1 & g1);
    assign g2_n = ~(g2 & g2);
    assign Cout = ~(g1_n & g2_n);

endmodule

// File: rtl/serial_adder_nand.sv
// Bit-serial WIDTH-bit adder: one bit per cycle LSB first through a NAND full adder.
// Latency: start accepted at edge t, done pulse in cycle t+WIDTH+1.
// Backpressure: start is only honoured in IDLE; busy covers RUN, extra starts are dropped.
module serial_adder_nand
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e           state_q,  state_d;
    logic [WIDTH-1:0] a_sr_q,   a_sr_d;
    logic [WIDTH-1:0] b_sr_q,   b_sr_d;
    logic             c_q,      c_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    // Only WIDTH-1 partial bits are ever held; the last bit goes straight into sum.
    logic [WIDTH-2:0] sum_sr_q, sum_sr_d;
    logic [WIDTH-1:0] sum_q,    sum_d;
    logic             cout_q,   cout_d;

    logic             fa_s;
    logic             fa_co;
    logic [WIDTH-1:0] sum_next;

    full_adder_nand u_fa (
        .A    (a_sr_q[0]),
        .B    (b_sr_q[0]),
        .Cin  (c_q),
        .Sum  (fa_s),
        .Cout (fa_co)
    );

    assign sum_next = {fa_s, sum_sr_q};

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        c_d      = c_q;
        cnt_d    = cnt_q;
        sum_sr_d = sum_sr_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sr_d   = a;
                    b_sr_d   = b;
                    c_d      = cin;
                    cnt_d    = '0;
                    sum_sr_d = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                sum_sr_d = sum_next[WIDTH-1:1];
                c_d      = fa_co;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    sum_d   = sum_next;
                    cout_d  = fa_co;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            c_q      <= 1'b0;
            cnt_q    <= '0;
            sum_sr_q <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            c_q      <= c_d;
            cnt_q    <= cnt_d;
            sum_sr_q <= sum_sr_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_nand.sv
// Directed bench for serial_adder_nand: WIDTH=8 directed vectors plus exhaustive WIDTH=4.
module tb_serial_adder_nand;

    logic       clk;
    logic       rst_n;

    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;

    logic       start4, cin4, busy4, done4, cout4;
    logic [3:0] a4, b4, sum4;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    serial_adder_nand #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
    );

    serial_adder_nand #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .cin   (cin4),
        .busy  (busy4),
        .done  (done4),
        .sum   (sum4),
        .cout  (cout4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One WIDTH=8 add with hand-computed expected result; checks latency and the done pulse.
    task automatic run8(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                        input logic [7:0] exp_sum, input logic exp_cout, input string tag);
        int n;
        int busy_n;
        a8 = ta; b8 = tb_; cin8 = tc; start8 = 1'b1;
        step();
        start8 = 1'b0;
        a8 = ~ta; b8 = ~tb_; cin8 = ~tc;
        n = 1;
        busy_n = 0;
        while (!done8 && n < 40) begin
            if (busy8) busy_n++;
            step();
            n++;
        end
        chk({tag, "_done"}, done8, 1);
        chk({tag, "_lat"}, n, 9);
        chk({tag, "_busy_cycles"}, busy_n, 8);
        chk({tag, "_sum"}, sum8, exp_sum);
        chk({tag, "_cout"}, cout8, exp_cout);
        step();
        chk({tag, "_done_pulse"}, done8, 0);
    endtask

    task automatic run4(input logic [3:0] ta, input logic [3:0] tb_, input logic tc);
        int n;
        logic [4:0] exp;
        exp = 5'(ta) + 5'(tb_) + 5'(tc);
        a4 = ta; b4 = tb_; cin4 = tc; start4 = 1'b1;
        step();
        start4 = 1'b0;
        a4 = ~ta;
        n = 1;
        while (!done4 && n < 30) begin
            step();
            n++;
        end
        chk("w4_lat", n, 5);
        chk("w4_result", {cout4, sum4}, exp);
        step();
    endtask

    initial begin
        int dn;
        int n;
        rst_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        step();
        step();
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        chk("rst_sum", sum8, 0);
        chk("rst_cout", cout8, 0);
        rst_n = 1'b1;
        step();

        run8(8'h15, 8'h27, 1'b0, 8'h3C, 1'b0, "basic");
        run8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "wrap");
        run8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "all_ones");
        run8(8'h80, 8'h7F, 1'b1, 8'h00, 1'b1, "mid_ripple");

        // start held through RUN, operand changes mid-run must not leak in
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
        step();
        step();
        step();
        a8 = 8'hAA;
        dn = 0;
        n = 0;
        while (!done8 && n < 40) begin
            step();
            n++;
        end
        while (done8 && n < 40) begin
            dn++;
            step();
            n++;
        end
        chk("ign_sum", sum8, 8'h30);
        chk("ign_one_done", dn, 1);
        chk("ign_idle_after_done", busy8, 0);
        step();
        chk("ign_reaccept", busy8, 1);
        start8 = 1'b0;
        chk("ign_hold_sum", sum8, 8'h30);
        n = 0;
        while (!done8 && n < 40) begin
            step();
            n++;
        end
        chk("ign_second_sum", sum8, 8'hCA);
        chk("ign_second_cout", cout8, 0);
        step();

        run8(8'd5, 8'd6, 1'b0, 8'd11, 1'b0, "b2b_first");
        step();
        step();
        chk("hold_sum", sum8, 8'd11);
        chk("hold_cout", cout8, 0);
        run8(8'd100, 8'd200, 1'b0, 8'h2C, 1'b1, "b2b_second");

        // reset in the middle of an add
        a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
        step();
        start8 = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        step();
        chk("midrst_busy", busy8, 0);
        chk("midrst_sum", sum8, 0);
        chk("midrst_cout", cout8, 0);
        chk("midrst_done", done8, 0);
        rst_n = 1'b1;
        dn = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done8) dn++;
        end
        chk("midrst_no_done", dn, 0);
        run8(8'd3, 8'd4, 1'b0, 8'd7, 1'b0, "after_rst");

        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    run4(4'(ia), 4'(ib), 1'(ic));
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
